mc_ctrl_fsm: RTL

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_pkg.sv | 64 ++++++
 rtl/mc_ctrl_fsm_op_class.sv | 39 +++
 rtl/mc_ctrl_fsm.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
    ST_R_EXEC, ST_I_EXEC, ST_ALU_WB, ST_BRANCH, ST_JUMP, ST_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  typedef struct packed {
    logic is_r;
    logic is_mem;
    logic is_load;
    logic is_branch;
    logic is_jump;
    logic is_jal;
    logic is_imm;
    logic is_illegal;
    logic is_jr;
    logic is_jalr;
  } op_class_t;

endpackage

// File: rtl/mc_ctrl_fsm_op_class.sv
// Opcode/funct classification for the control FSM.
module mc_op_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output op_class_t  o_class
);

  always_comb begin
    o_class = '0;
    case (i_op)
      OP_RTYPE: begin
        o_class.is_r    = 1'b1;
        o_class.is_jr   = (i_funct == FN_JR);
        o_class.is_jalr = (i_funct == FN_JALR);
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        o_class.is_mem  = 1'b1;
        o_class.is_load = 1'b1;
      end
      OP_SB, OP_SH, OP_SW:
        o_class.is_mem = 1'b1;
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
        o_class.is_branch = 1'b1;
      OP_J:
        o_class.is_jump = 1'b1;
      OP_JAL: begin
        o_class.is_jump = 1'b1;
        o_class.is_jal  = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        o_class.is_imm = 1'b1;
      default:
        o_class.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle processor control FSM with memory handshake, timeout trap and retire counter.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HS  = 1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       reg_dst,
  output logic             reg_write,
  output logic             imem_read,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             pc_write,
  output logic             ir_write,
  output logic             pc_write_cond,
  output logic [1:0]       ext_op,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_wait;
  logic             r_trap;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause;
  logic [CNT_W-1:0] r_retired;
  op_class_t        w_cls;
  logic             w_imem_ok;
  logic             w_dmem_ok;
  logic             w_timeout;

  mc_op_class u_op_class (
    .i_op    (op),
    .i_funct (funct),
    .o_class (w_cls)
  );

  assign w_imem_ok = (MEM_HS == 0) || imem_ready;
  assign w_dmem_ok = (MEM_HS == 0) || dmem_ready;
  // r_wait counts completed wait cycles, so the last allowed one is TIMEOUT-1
  assign w_timeout = (TIMEOUT != 0) && (r_wait == 32'(TIMEOUT - 1));

  always_comb begin
    w_next        = r_state;
    w_cause       = CAUSE_NONE;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    mem_to_reg    = 2'd0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    imem_read     = 1'b0;
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    pc_write_cond = 1'b0;
    ext_op        = 2'd0;
    alu_op        = ALU_ADD;
    pc_source     = PC_ALU;
    case (r_state)
      ST_FETCH: begin
        imem_read = 1'b1;
        alu_src_b = 2'd1;
        if (w_imem_ok) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_timeout) begin
          w_next  = ST_TRAP;
          w_cause = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        alu_src_b = 2'd3;
        ext_op    = 2'd1;
        if (w_cls.is_r)                          w_next = ST_R_EXEC;
        else if (w_cls.is_mem)                   w_next = ST_MEM_ADDR;
        else if (w_cls.is_branch)                w_next = ST_BRANCH;
        else if (w_cls.is_jump)                  w_next = ST_JUMP;
        else if (w_cls.is_imm && !w_cls.is_illegal) w_next = ST_I_EXEC;
        else begin
          w_next  = ST_TRAP;
          w_cause = CAUSE_ILLEGAL;
        end
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext_op    = 2'd1;
        w_next    = w_cls.is_load ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        dmem_read = 1'b1;
        if (w_dmem_ok) w_next = ST_MEM_WB;
        else if (w_timeout) begin
          w_next  = ST_TRAP;
          w_cause = CAUSE_DMEM_TO;
        end
      end
      ST_MEM_WR: begin
        dmem_write = 1'b1;
        if (w_dmem_ok) w_next = ST_FETCH;
        else if (w_timeout) begin
          w_next  = ST_TRAP;
          w_cause = CAUSE_DMEM_TO;
        end
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        reg_dst    = 2'd1;
        w_next     = ST_FETCH;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        if (w_cls.is_jr || w_cls.is_jalr) begin
          pc_source = PC_RS;
          pc_write  = 1'b1;
          w_next    = ST_FETCH;
          if (w_cls.is_jalr) begin
            reg_write  = 1'b1;
            mem_to_reg = 2'd2;
            reg_dst    = 2'd0;
          end
        end else begin
          w_next = ST_ALU_WB;
        end
      end
      ST_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_FUNCT;
        w_next    = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op == OP_RTYPE) ? 2'd0 : 2'd1;
        w_next    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        ext_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = PC_ALUOUT;
        w_next        = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_JUMP;
        if (w_cls.is_jal) begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd2;
          reg_dst    = 2'd2;
        end
        w_next = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_wait    <= '0;
      r_trap    <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait <= '0;
      else if (r_state == ST_FETCH || r_state == ST_MEM_RD || r_state == ST_MEM_WR)
        r_wait <= r_wait + 32'd1;
      if (w_next == ST_TRAP && r_state != ST_TRAP) begin
        r_trap  <= 1'b1;
        r_cause <= w_cause;
      end
      if (w_next == ST_FETCH && r_state != ST_FETCH && r_state != ST_TRAP)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign trap       = r_trap;
  assign trap_cause = r_cause;
  assign retired    = r_retired;

endmodule
